// File: rtl/student_fir_pkg.sv
// Shared types for the FIR datapath.
// Sample width and sample-buffer sequencer states.
package student_fir_pkg;

  localparam int unsigned SampleW = 16;

  typedef logic [SampleW-1:0] sample_t;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    READ,
    DRAIN
  } buf_state_e;

endpackage

// File: rtl/student_sample_buffer_ctrl.sv
// Circular-buffer sequencer for the FIR sample DPRAM.
// Writes one sample per handshake, then replays newest taps.
module student_sample_buffer_ctrl
  import student_fir_pkg::*;
#(
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned DataSize     = 16,
  parameter int unsigned NumTaps      = 1024,
  parameter bit          ClearOnReset = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic                 ram_ena_o,
  output logic                 ram_wea_o,
  output logic [AddrWidth-1:0] ram_addra_o,
  output logic [DataSize-1:0]  ram_dia_o,
  output logic                 ram_enb_o,
  output logic [AddrWidth-1:0] ram_addrb_o,
  input  logic [DataSize-1:0]  ram_dob_i,
  output logic [DataSize-1:0]  tap_sample_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_valid_o,
  output logic                 tap_first_o,
  output logic                 tap_last_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam logic [AddrWidth:0] LastK =
    (AddrWidth+1)'(NumTaps - 1);
  localparam logic [AddrWidth-1:0] LastA = '1;

  buf_state_e           state_q;
  logic [AddrWidth-1:0] wr_ptr_q;
  logic [AddrWidth-1:0] base_q;
  logic [AddrWidth-1:0] clr_cnt_q;
  logic [AddrWidth-1:0] clr_addr_q;
  logic [AddrWidth:0]   k_q;
  logic                 clr_we_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 tap_valid_q;
  logic                 tap_first_q;
  logic                 tap_last_q;
  logic                 done_q;
  logic [AddrWidth-1:0] tap_idx_q;
  logic                 accept;
  logic                 rd_last;

  assign accept  = sample_valid_i & ready_q;
  assign rd_last = (k_q == LastK);

  assign sample_ready_o = ready_q;
  assign busy_o         = busy_q;

  assign ram_ena_o   = clr_we_q | accept;
  assign ram_wea_o   = clr_we_q | accept;
  assign ram_addra_o = clr_we_q ? clr_addr_q : wr_ptr_q;
  assign ram_dia_o   = clr_we_q ? '0 : sample_i;

  assign ram_enb_o   = (state_q == READ);
  assign ram_addrb_o = base_q - k_q[AddrWidth-1:0];

  assign tap_sample_o = ram_dob_i;
  assign tap_idx_o    = tap_idx_q;
  assign tap_valid_o  = tap_valid_q;
  assign tap_first_o  = tap_first_q;
  assign tap_last_o   = tap_last_q;
  assign done_o       = done_q;

  // Sequencer: clear sweep, accept, tap replay, pointer advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (ClearOnReset) state_q <= CLEAR;
      else              state_q <= IDLE;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      clr_cnt_q  <= '0;
      clr_addr_q <= '0;
      k_q        <= '0;
      clr_we_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_we_q   <= 1'b1;
          clr_addr_q <= clr_cnt_q;
          clr_cnt_q  <= clr_cnt_q + 1'b1;
          busy_q     <= 1'b1;
          if (clr_cnt_q == LastA) state_q <= IDLE;
        end
        IDLE: begin
          clr_we_q <= 1'b0;
          ready_q  <= ~accept;
          busy_q   <= accept;
          if (accept) begin
            base_q  <= wr_ptr_q;
            k_q     <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          k_q <= k_q + 1'b1;
          if (rd_last) state_q <= DRAIN;
        end
        DRAIN: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tap flags trail each port-B read by one cycle, matching RAM latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap_valid_q <= 1'b0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
      done_q      <= 1'b0;
      tap_idx_q   <= '0;
    end else begin
      tap_valid_q <= (state_q == READ);
      tap_first_q <= (state_q == READ) & (k_q == '0);
      tap_last_q  <= (state_q == READ) & rd_last;
      done_q      <= (state_q == READ) & rd_last;
      tap_idx_q   <= k_q[AddrWidth-1:0];
    end
  end

endmodule
